// File: rtl/icache_fill_controller.sv
// icache_fill_controller
// Direct-mapped instruction cache with a sequential line-fill engine.
//   Hits in IDLE return data combinationally (zero-cycle hit). A miss latches the
//   line address and fetches BLOCKS words in order (word 0 first) from memory,
//   then passes through FINISH to mark the line valid before the held request hits.
// Ports:
//   i_clock, i_reset            : clock, synchronous active-high reset
//   i_rd, i_addr                : CPU fetch request (held until o_ready)
//   o_data, o_ready             : fetched word, fetch-complete strobe
//   i_invalidate                : one-cycle pulse, invalidate all lines
//   o_mem_rd, o_mem_addr        : memory word read request / byte address
//   i_mem_data, i_mem_ready     : memory read data / accept+return strobe
//   o_hit_count, o_miss_count   : 32-bit statistics (only with RV_ICACHE_STATS_EN)
// Optional feature macro: RV_ICACHE_STATS_EN
module icache_fill_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 64,
  parameter int BLOCKS     = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rd,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ready,
  input  logic                  i_invalidate,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_ready
`ifdef RV_ICACHE_STATS_EN
  ,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count
`endif
);

  localparam int WRD_W = $clog2(BLOCKS);
  localparam int IDX_W = $clog2(ELEMENTS);
  localparam int TAG_W = ADDR_WIDTH - 2 - WRD_W - IDX_W;
  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, FILL, FINISH} state_e;

  state_e                  state_q;
  logic [ELEMENTS-1:0]     valid_q;
  logic [TAG_W-1:0]        tag_q  [ELEMENTS];
  logic [DATA_WIDTH-1:0]   data_q [ELEMENTS*BLOCKS];
  logic [TAG_W-1:0]        ftag_q;
  logic [IDX_W-1:0]        fidx_q;
  logic [WRD_W-1:0]        cnt_q;
  logic                    inv_pend_q;
  logic                    mem_rd_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
`ifdef RV_ICACHE_STATS_EN
  logic [31:0]             hit_cnt_q;
  logic [31:0]             miss_cnt_q;
`endif

  // Address decode of the live CPU request
  logic [WRD_W-1:0] req_word;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             unused_lsb;

  assign req_word   = i_addr[2 +: WRD_W];
  assign req_idx    = i_addr[2+WRD_W +: IDX_W];
  assign req_tag    = i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused_lsb = ^i_addr[1:0];

  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign o_ready = (state_q == IDLE) && i_rd && hit;
  assign o_data  = data_q[{req_idx, req_word}];

  assign o_mem_rd   = mem_rd_q;
  assign o_mem_addr = mem_addr_q;
`ifdef RV_ICACHE_STATS_EN
  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`endif

  // Line storage: no reset, contents only trusted through valid_q
  always_ff @(posedge i_clock) begin
    if (!i_reset && state_q == FILL && i_mem_ready) begin
      data_q[{fidx_q, cnt_q}] <= i_mem_data;
      if (cnt_q == LAST_WORD) tag_q[fidx_q] <= ftag_q;
    end
  end

  // Control FSM; memory request outputs are registered here
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      ftag_q     <= '0;
      fidx_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
`ifdef RV_ICACHE_STATS_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Lookup above used the pre-clear valid bits, so a same-cycle hit still hits
          if (i_invalidate) valid_q <= '0;
          if (i_rd && !hit) begin
            ftag_q     <= req_tag;
            fidx_q     <= req_idx;
            cnt_q      <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {req_tag, req_idx, {WRD_W{1'b0}}, 2'b00};
            state_q    <= FILL;
`ifdef RV_ICACHE_STATS_EN
            miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
          end
`ifdef RV_ICACHE_STATS_EN
          if (o_ready) hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
        end
        FILL: begin
          if (i_invalidate) inv_pend_q <= 1'b1;
          if (i_mem_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
              mem_rd_q   <= 1'b0;
              mem_addr_q <= '0;
              state_q    <= FINISH;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(4);
            end
          end
        end
        FINISH: begin
          // An invalidate seen during the fill wipes everything, including the new line
          if (inv_pend_q || i_invalidate) valid_q <= '0;
          else                            valid_q[fidx_q] <= 1'b1;
          inv_pend_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_controller.sv
module tb_icache_fill_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic [31:0] addr = '0;
  logic        inv = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] data, mem_addr, mem_data;
  logic        ready, mem_rd;
`ifdef RV_ICACHE_STATS_EN
  logic [31:0] hits, misses;
`endif

  always #5 clk = ~clk;

  icache_fill_controller dut (
    .i_clock(clk), .i_reset(rst), .i_rd(rd), .i_addr(addr),
    .o_data(data), .o_ready(ready), .i_invalidate(inv),
    .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
    .i_mem_data(mem_data), .i_mem_ready(mem_ready)
`ifdef RV_ICACHE_STATS_EN
    , .o_hit_count(hits), .o_miss_count(misses)
`endif
  );

  // Memory image: each word carries its own low address bits
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction
  assign mem_data = mem_word(mem_addr);

  typedef struct {logic [31:0] data; int lat;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int checks = 0, passes = 0;
  int cyc = 0, req_cyc = 0;
  bit got_ready = 0;
  bit stall = 0;
  int wc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: always ready, or 3 wait cycles before each accepted word
  always @(posedge clk) begin
    #1;
    if (!stall) mem_ready = 1'b1;
    else if (mem_rd) begin
      if (wc == 3) begin mem_ready = 1'b1; wc = 0; end
      else begin mem_ready = 1'b0; wc++; end
    end else begin
      mem_ready = 1'b0; wc = 0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_ready: got ready=1 addr %h, expected no response", addr);
      end else begin
        e = exp_q.pop_front();
        check("rdata", data, e.data);
        check("latency", 32'(cyc - req_cyc), 32'(e.lat));
        got_ready = 1;
      end
    end
    if (mem_rd === 1'b1) begin
      if (addr_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_mem_rd: got mem_rd=1 addr %h, expected mem_rd=0", mem_addr);
      end else if (mem_ready) check("mem_addr_beat", mem_addr, addr_q.pop_front());
      else check("mem_addr_stall", mem_addr, addr_q[0]);
    end
  end

  // Issue one fetch at posedge+2 and hold it until the monitor sees o_ready
  task automatic fetch(input logic [31:0] a, input int nfills, input int lat, input bit with_inv);
    exp_t e;
    int n = 0;
    e.data = mem_word(a); e.lat = lat;
    exp_q.push_back(e);
    for (int f = 0; f < nfills; f++)
      for (int k = 0; k < 4; k++) addr_q.push_back({a[31:4], 4'h0} + 32'(4 * k));
    got_ready = 0; req_cyc = cyc; rd = 1'b1; addr = a;
    if (with_inv) inv = 1'b1;
    while (!got_ready && n < 100) begin
      @(posedge clk); #2;
      if (with_inv) inv = 1'b0;
      n++;
    end
    if (!got_ready) begin
      checks++;
      $display("FAIL fetch_timeout: addr %h got no ready, expected ready", a);
      exp_q.delete(); addr_q.delete();
    end
    rd = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_mem_rd", 32'(mem_rd), 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #2 rst = 1'b0;

    fetch(32'h0000_0100, 1, 6, 0);   // cold miss
    fetch(32'h0000_0108, 0, 0, 0);   // zero-cycle hit, third word
    fetch(32'h0000_1100, 1, 6, 0);   // same index, new tag
    fetch(32'h0000_0100, 1, 6, 0);   // evicted -> miss again
    stall = 1'b1;
    fetch(32'h0000_0300, 1, 18, 0);  // 3 wait cycles per word
    stall = 1'b0;
    fetch(32'h0000_0300, 0, 0, 0);
    fetch(32'h0000_030C, 0, 0, 0);
    fetch(32'h0000_0304, 0, 0, 0);
    fetch(32'h0000_0300, 0, 0, 1);   // invalidate in IDLE: still hits this cycle
    fetch(32'h0000_0300, 1, 6, 0);   // ...then misses
    // Invalidate during second beat: line fills but is not kept, held request refills
    fork
      fetch(32'h0000_0200, 2, 12, 0);
      begin
        repeat (2) @(posedge clk);
        #3 inv = 1'b1;
        @(posedge clk);
        #3 inv = 1'b0;
      end
    join
    fetch(32'h0000_0100, 1, 6, 0);   // wiped by the invalidate
    fetch(32'h0000_0208, 0, 0, 0);

    // Reset after two fill beats
    addr_q.push_back(32'h400); addr_q.push_back(32'h404);
    req_cyc = cyc; addr = 32'h400; rd = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1; rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'h0);
    check("rst_mid_ready", 32'(ready), 32'd0);
`ifdef RV_ICACHE_STATS_EN
    check("rst_hits", hits, 32'd0);
    check("rst_misses", misses, 32'd0);
`endif
    @(posedge clk); #2 rst = 1'b0;
    fetch(32'h0000_0400, 1, 6, 0);   // partial line never became valid
    fetch(32'h0000_0100, 1, 6, 0);   // reset cleared all valid bits
`ifdef RV_ICACHE_STATS_EN
    @(negedge clk);
    check("stat_hits", hits, 32'd2);
    check("stat_misses", misses, 32'd2);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("leftover_responses", 32'(exp_q.size()), 32'd0);
    check("leftover_beats", 32'(addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
